rr_arbiter_tmo: RTL and testbench

//  Parametrised round-robin arbiter for coprocessor shared resources (bus, ALU, memory port).

---
 rtl/rr_arbiter_tmo.sv | 117 +++++++++++
 tb/tb_rr_arbiter_tmo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_tmo.sv
// rtl/rr_arbiter_tmo.sv - round-robin arbiter with eligibility mask, grant index, busy flag
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_tmo #(
   parameter int WIDTH   = 4,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 16
) (
   input  logic             in_clk,
   input  logic             in_reset,
   input  logic [WIDTH-1:0] in_request,
   input  logic [WIDTH-1:0] in_mask,
   output logic [WIDTH-1:0] out_grant,
   output logic [IDX_W-1:0] out_grant_idx,
   output logic             out_busy,
   output logic             out_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WORK  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   r_base;
   logic [WIDTH-1:0]   eligible;
   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] dbl_pick;
   logic [WIDTH-1:0]   winner;
   logic [IDX_W-1:0]   winner_idx;
   logic [WIDTH-1:0]   next_base;
   logic               owner_live;
   logic               expire;

   assign eligible = in_request & ~in_mask;

   // First eligible bit at or above r_base; the upper copy supplies the wrapped-around winner.
   assign dbl      = {eligible, eligible};
   assign dbl_pick = dbl & ~(dbl - {{WIDTH{1'b0}}, r_base});
   assign winner   = dbl_pick[WIDTH-1:0] | dbl_pick[2*WIDTH-1:WIDTH];

   always_comb begin
      winner_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (winner[i]) winner_idx = IDX_W'(i);
      end
   end

   assign owner_live = |(eligible & out_grant);
   assign next_base  = {out_grant[WIDTH-2:0], out_grant[WIDTH-1]};

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_cnt;

   assign expire = owner_live && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
   // Never true for a legal TIMEOUT: without the timeout feature a grant is held indefinitely.
   assign expire = (TIMEOUT < 1);
`endif

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state         <= ST_IDLE;
         r_base        <= WIDTH'(1);
         out_grant     <= '0;
         out_grant_idx <= '0;
         out_busy      <= 1'b0;
         out_timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_cnt         <= '0;
`endif
      end else begin
         out_timeout <= 1'b0;
         case (state)
            ST_GRANT: begin
               if (|eligible) begin
                  out_grant     <= winner;
                  out_grant_idx <= winner_idx;
                  out_busy      <= 1'b1;
                  state         <= ST_WORK;
`ifdef ARB_TIMEOUT_EN
                  r_cnt         <= '0;
`endif
               end else begin
                  out_grant     <= '0;
                  out_grant_idx <= '0;
                  out_busy      <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            ST_WORK: begin
               if (!owner_live || expire) begin
                  out_grant     <= '0;
                  out_grant_idx <= '0;
                  out_busy      <= 1'b0;
                  out_timeout   <= expire;
                  r_base        <= next_base;
                  state         <= (|eligible) ? ST_GRANT : ST_IDLE;
`ifdef ARB_TIMEOUT_EN
               end else if (r_cnt != CNT_W'(TIMEOUT)) begin
                  r_cnt         <= r_cnt + 1'b1;
`endif
               end
            end
            default: begin
               // IDLE and any illegal encoding
               out_grant     <= '0;
               out_grant_idx <= '0;
               out_busy      <= 1'b0;
               state         <= (|eligible) ? ST_GRANT : ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_tmo.sv
// tb/tb_rr_arbiter_tmo.sv - self-checking bench for rr_arbiter_tmo against a behavioural model
// Honours ARB_TIMEOUT_EN the same way as the design.
module tb_rr_arbiter_tmo;

   localparam int W   = 4;
   localparam int TMO = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] req;
   logic [W-1:0] mask;
   logic [W-1:0] out_grant;
   logic [1:0]   out_grant_idx;
   logic         out_busy;
   logic         out_timeout;

   int checks = 0;
   int fails  = 0;
   bit chk_en = 0;

   // model state: mode 0 = idle, 1 = arbitrating, 2 = owned
   int           m_mode;
   int           m_owner;
   int           m_base;
   int           m_held;
   logic [W-1:0] e_grant;
   logic [1:0]   e_idx;
   logic         e_busy;
   logic         e_tmo;

   rr_arbiter_tmo #(.WIDTH(W), .IDX_W(2), .TIMEOUT(TMO)) dut (
      .in_clk        (clk),
      .in_reset      (rst_n),
      .in_request    (req),
      .in_mask       (mask),
      .out_grant     (out_grant),
      .out_grant_idx (out_grant_idx),
      .out_busy      (out_busy),
      .out_timeout   (out_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [W-1:0] el, input int base);
      for (int k = 0; k < W; k++) begin
         if (el[(base + k) % W]) return (base + k) % W;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_mode  = 0;
      m_owner = 0;
      m_base  = 0;
      m_held  = 0;
      e_grant = '0;
      e_idx   = '0;
      e_busy  = 1'b0;
      e_tmo   = 1'b0;
   endtask

   task automatic model_step();
      logic [W-1:0] el;
      bit           rel;
      bit           tmo;
      if (!rst_n) begin
         model_reset();
         return;
      end
      el    = req & ~mask;
      e_tmo = 1'b0;
      case (m_mode)
         1: begin
            if (el == '0) m_mode = 0;
            else begin
               m_owner = pick(el, m_base);
               m_mode  = 2;
               m_held  = 1;
            end
         end
         2: begin
            rel = !el[m_owner];
            tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo = !rel && (m_held >= TMO);
`endif
            if (rel || tmo) begin
               m_base = (m_owner + 1) % W;
               e_tmo  = tmo;
               m_mode = (el != '0) ? 1 : 0;
            end else begin
               m_held++;
            end
         end
         default: m_mode = (el != '0) ? 1 : 0;
      endcase
      e_grant = '0;
      e_idx   = '0;
      e_busy  = 1'b0;
      if (m_mode == 2) begin
         e_grant[m_owner] = 1'b1;
         e_idx            = 2'(m_owner);
         e_busy           = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (out_grant !== e_grant || out_grant_idx !== e_idx ||
             out_busy !== e_busy || out_timeout !== e_tmo) begin
            fails++;
            $display("FAIL model_cmp t=%0t got grant=%b idx=%0d busy=%b tmo=%b expected grant=%b idx=%0d busy=%b tmo=%b",
                     $time, out_grant, out_grant_idx, out_busy, out_timeout,
                     e_grant, e_idx, e_busy, e_tmo);
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      step();
      rst_n = 1'b1;
   endtask

   logic [W-1:0] order_exp [5];
   int           n;
   int           gap;
   int           held;

   initial begin
      order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst_n = 1'b0;
      req   = '0;
      mask  = '0;
      model_reset();
      chk_en = 1;
      step();
      step();
      check("reset_grant", out_grant, 0);
      check("reset_idx", out_grant_idx, 0);
      check("reset_busy", out_busy, 0);
      check("reset_tmo", out_timeout, 0);
      rst_n = 1'b1;

      // idle and a request pulse lost before arbitration
      repeat (3) step();
      check("idle_busy", out_busy, 0);
      req = 4'b0010;
      step();
      req = 4'b0000;
      step();
      step();
      check("pulse_lost_grant", out_grant, 0);
      step();
      check("pulse_lost_busy", out_busy, 0);

      // async reset while owned
      req = 4'b0100;
      step();
      step();
      check("own_grant", out_grant, 4'b0100);
      check("own_idx", out_grant_idx, 2);
      step();
      rst_n = 1'b0;
      #1;
      check("async_rst_grant", out_grant, 0);
      check("async_rst_busy", out_busy, 0);
      check("async_rst_idx", out_grant_idx, 0);
      model_reset();
      rst_n = 1'b1;
      req   = 4'b0001;
      step();
      step();
      check("post_rst_grant", out_grant, 4'b0001);

      // rotation with one idle cycle between owners
      do_reset();
      req = 4'b1111;
      n   = 0;
      gap = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         step();
         if (out_grant != '0) begin
            check($sformatf("order%0d", n), out_grant, order_exp[n]);
            if (n > 0) check($sformatf("gap%0d", n), gap, 1);
            n++;
            gap = 0;
            req = 4'b1111 & ~out_grant;
         end else begin
            gap++;
            req = 4'b1111;
         end
      end
      check("order_count", n, 5);
      req = '0;
      repeat (3) step();

      // wrap from bit 3 to bit 0
      do_reset();
      req = 4'b1000;
      step();
      step();
      check("wrap_owner", out_grant, 4'b1000);
      check("wrap_owner_idx", out_grant_idx, 3);
      req  = 4'b1001;
      mask = 4'b1000;
      step();
      check("wrap_release", out_grant, 0);
      step();
      check("wrap_grant", out_grant, 4'b0001);
      check("wrap_idx", out_grant_idx, 0);
      req  = '0;
      mask = '0;
      repeat (2) step();

      // mask excludes new grants and revokes a hold
      req  = 4'b0110;
      mask = 4'b0010;
      step();
      step();
      check("mask_grant", out_grant, 4'b0100);
      mask = 4'b0100;
      step();
      check("mask_revoke", out_grant, 0);
      step();
      check("mask_next", out_grant, 4'b0010);
      req  = '0;
      mask = '0;
      repeat (2) step();

      // hold length and timeout
      do_reset();
      req = 4'b0011;
      step();
      step();
      held = 0;
      for (int c = 0; c < 120 && out_grant == 4'b0001; c++) begin
         held++;
         step();
      end
`ifdef ARB_TIMEOUT_EN
      check("tmo_hold_len", held, TMO);
      check("tmo_pulse", out_timeout, 1);
      step();
      check("tmo_pulse_end", out_timeout, 0);
      check("tmo_next", out_grant, 4'b0010);
`else
      check("hold_len", held, 120);
      check("no_tmo", out_timeout, 0);
`endif
      req = '0;
      repeat (3) step();

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         if ($urandom_range(0, 3) == 0) req[$urandom_range(0, W - 1)] ^= 1'b1;
         if ($urandom_range(0, 15) == 0) mask = W'($urandom_range(0, 15)) & W'($urandom_range(0, 15));
         step();
      end

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
